alu_op_issuer: RTL and testbench

- Initiator side of the ALU datapath interface. Accepts one decoded operation per handshake from the decode stage and translates ALUOp/funct fields into the 4-bit ALU control code.
- Drives registered operands and the control code to the combinational ALU, captures the ALU result and zero flag, resolves BEQ/BNE, and returns a held response.
- Sits between the control/decode logic and the ALU in the multi-cycle datapath.

---
 rtl/alu_op_issuer.sv | 183 ++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - decode/issue stage driving the combinational ALU with a held response (optional SLT via ALU_SLT_EN)
module alu_op_issuer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
`ifdef ALU_SLT_EN
  localparam logic [3:0] CTRL_SLT = 4'b0111;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_EQ,
    BR_NE
  } br_t;

  state_t           state_q, state_d;
  br_t              br_q, br_d;
  logic             ill_pend_q, ill_pend_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             branch_taken_q, branch_taken_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       dec_ctrl;
  logic             dec_illegal;
  br_t              dec_br;
  logic             cap_zero;

  // Translate ALUOp/funct fields into the ALU code, branch kind and legality
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    dec_br      = BR_NONE;
    case (alu_op)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: begin
        case (funct3)
          3'b000: begin
            dec_ctrl = CTRL_SUB;
            dec_br   = BR_EQ;
          end
          3'b001: begin
            dec_ctrl = CTRL_SUB;
            dec_br   = BR_NE;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        case (funct3)
          3'b000: dec_ctrl = (funct7b5 && !alu_src) ? CTRL_SUB : CTRL_ADD;
          3'b111: dec_ctrl = CTRL_AND;
          3'b110: dec_ctrl = CTRL_OR;
`ifdef ALU_SLT_EN
          3'b010: dec_ctrl = CTRL_SLT;
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // The ALU zero flag is only meaningful for SUB, and an illegal op reports no flags
  assign cap_zero = !ill_pend_q && (alu_ctrl_q == CTRL_SUB) && alu_zero;

  // Next-state and register updates for the accept / issue / respond sequence
  always_comb begin
    state_d        = state_q;
    br_d           = br_q;
    ill_pend_d     = ill_pend_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_ctrl_d     = alu_ctrl_q;
    result_d       = result_q;
    zero_d         = zero_q;
    branch_taken_d = branch_taken_q;
    illegal_d      = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          alu_a_d    = rs1_data;
          alu_b_d    = alu_src ? imm : rs2_data;
          alu_ctrl_d = dec_ctrl;
          ill_pend_d = dec_illegal;
          br_d       = dec_illegal ? BR_NONE : dec_br;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        result_d  = ill_pend_q ? '0 : alu_result;
        zero_d    = cap_zero;
        illegal_d = ill_pend_q;
        case (br_q)
          BR_EQ:   branch_taken_d = cap_zero;
          BR_NE:   branch_taken_d = !cap_zero;
          default: branch_taken_d = 1'b0;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      br_q           <= BR_NONE;
      ill_pend_q     <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= CTRL_ADD;
      result_q       <= '0;
      zero_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      br_q           <= br_d;
      ill_pend_q     <= ill_pend_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_ctrl_q     <= alu_ctrl_d;
      result_q       <= result_d;
      zero_q         <= zero_d;
      branch_taken_q <= branch_taken_d;
      illegal_q      <= illegal_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_DONE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - self-checking bench for alu_op_issuer with an ALU model and reference decoder
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        alu_src;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        zero;
  logic        branch_taken;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    int          hold;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        t;
    logic        ill;
  } vec_t;

  alu_op_issuer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .alu_src(alu_src),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .result(result), .zero(zero), .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Combinational ALU seen by the issuer
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected response from the instruction fields, straight from the decode rules
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [31:0] b;
    r = v;
    b = v.src ? v.imm : v.rs2;
    r.ctrl = 4'b0010; r.res = 32'd0; r.z = 1'b0; r.t = 1'b0; r.ill = 1'b0;
    if (v.op == 2'd0) begin
      r.res = v.rs1 + b;
    end else if (v.op == 2'd1 && (v.f3 == 3'd0 || v.f3 == 3'd1)) begin
      r.ctrl = 4'b0110;
      r.res  = v.rs1 - b;
      r.z    = (v.rs1 == b);
      r.t    = (v.f3 == 3'd0) ? r.z : !r.z;
    end else if (v.op == 2'd2 && v.f3 == 3'd0) begin
      if (v.f7 && !v.src) begin
        r.ctrl = 4'b0110;
        r.res  = v.rs1 - b;
        r.z    = (v.rs1 == b);
      end else begin
        r.res = v.rs1 + b;
      end
    end else if (v.op == 2'd2 && v.f3 == 3'd7) begin
      r.ctrl = 4'b0000;
      r.res  = v.rs1 & b;
    end else if (v.op == 2'd2 && v.f3 == 3'd6) begin
      r.ctrl = 4'b0001;
      r.res  = v.rs1 | b;
`ifdef ALU_SLT_EN
    end else if (v.op == 2'd2 && v.f3 == 3'd2) begin
      r.ctrl = 4'b0111;
      r.res  = ($signed(v.rs1) < $signed(b)) ? 32'd1 : 32'd0;
`endif
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic drive_fields(input vec_t v);
    alu_op   = v.op;
    funct3   = v.f3;
    funct7b5 = v.f7;
    alu_src  = v.src;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    imm      = v.imm;
  endtask

  // One full transaction; called and sampled 1ns after a rising edge
  task automatic run_op(input string tag, input vec_t v);
    logic [31:0] exp_b;
    exp_b = v.src ? v.imm : v.rs2;
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    drive_fields(v);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(v.ctrl));
    chk({tag, ".alu_a"}, alu_a, v.rs1);
    chk({tag, ".alu_b"}, alu_b, exp_b);
    chk({tag, ".rsp_valid_issue"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".req_ready_issue"}, 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rsp_ready = (v.hold == 0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".result"}, result, v.res);
    chk({tag, ".zero"}, 32'(zero), 32'(v.z));
    chk({tag, ".branch_taken"}, 32'(branch_taken), 32'(v.t));
    chk({tag, ".illegal"}, 32'(illegal), 32'(v.ill));
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      rs1_data  = 32'($urandom);
      alu_op    = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      chk({tag, ".hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_result"}, result, v.res);
      chk({tag, ".hold_alu_a"}, alu_a, v.rs1);
      rsp_ready = (h == v.hold - 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_clear"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    alu_op = 2'd0; funct3 = 3'd0; funct7b5 = 1'b0; alu_src = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;

    //            op  f3  f7 src rs1           rs2          imm      hold ctrl  res           z  t  ill
    tbl.push_back('{2, 0, 1, 0, 32'd10,       32'd3,       32'd0,   0, 4'h6, 32'd7,       0, 0, 0}); // R SUB
    tbl.push_back('{1, 0, 0, 0, 32'h1234,     32'h1234,    32'd0,   1, 4'h6, 32'd0,       1, 1, 0}); // BEQ equal
    tbl.push_back('{1, 1, 0, 0, 32'h1234,     32'h1234,    32'd0,   0, 4'h6, 32'd0,       1, 0, 0}); // BNE equal
    tbl.push_back('{1, 1, 0, 0, 32'd5,        32'd3,       32'd0,   0, 4'h6, 32'd2,       0, 1, 0}); // BNE differ
    tbl.push_back('{0, 3, 1, 1, 32'hFFFFFFFF, 32'd9,       32'd1,   0, 4'h2, 32'd0,       0, 0, 0}); // load addr wrap
    tbl.push_back('{2, 0, 1, 1, 32'd5,        32'd99,      32'd7,   0, 4'h2, 32'd12,      0, 0, 0}); // ADDI, bit30 ignored
    tbl.push_back('{2, 7, 0, 0, 32'hF0F0,     32'h0FF0,    32'd0,   4, 4'h0, 32'h00F0,    0, 0, 0}); // AND, held 4 cycles
    tbl.push_back('{2, 6, 0, 0, 32'hF0,       32'h0F,      32'd0,   2, 4'h1, 32'hFF,      0, 0, 0}); // OR
    tbl.push_back('{1, 4, 0, 0, 32'd8,        32'd8,       32'd0,   0, 4'h2, 32'd0,       0, 0, 1}); // unsupported branch
    tbl.push_back('{3, 0, 0, 0, 32'd8,        32'd8,       32'd0,   0, 4'h2, 32'd0,       0, 0, 1}); // reserved alu_op
`ifdef ALU_SLT_EN
    tbl.push_back('{2, 2, 0, 0, 32'hFFFFFFFF, 32'd1,       32'd0,   0, 4'h7, 32'd1,       0, 0, 0}); // SLT -1 < 1
`else
    tbl.push_back('{2, 2, 0, 0, 32'hFFFFFFFF, 32'd1,       32'd0,   0, 4'h2, 32'd0,       0, 0, 1}); // SLT disabled
`endif

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.alu_ctrl", 32'(alu_ctrl), 32'h2);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_op($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset during ISSUE of ADD 5+7, after a BEQ left zero/branch_taken set
    run_op("pre_rst", tbl[1]);
    v = '{0, 0, 0, 0, 32'd5, 32'd7, 32'd0, 0, 4'h2, 32'd12, 0, 0, 0};
    drive_fields(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.req_ready", 32'(req_ready), 32'd1);
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.alu_ctrl", 32'(alu_ctrl), 32'h2);
    chk("midrst.alu_b", alu_b, 32'd0);
    chk("midrst.zero", 32'(zero), 32'd0);
    chk("midrst.branch_taken", 32'(branch_taken), 32'd0);
    @(posedge clk); #1;
    chk("midrst.no_rsp", 32'(rsp_valid), 32'd0);

    // Randomized operations against the reference decoder
    for (int i = 0; i < 60; i++) begin
      int pick;
      v.op  = 2'($urandom_range(0, 3));
      pick  = $urandom_range(0, 5);
      v.f3  = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd1 : (pick == 2) ? 3'd2 :
              (pick == 3) ? 3'd6 : (pick == 4) ? 3'd7 : 3'($urandom);
      v.f7  = 1'($urandom);
      v.src = 1'($urandom);
      v.rs1 = 32'($urandom);
      v.rs2 = ($urandom_range(0, 1) == 0) ? v.rs1 : 32'($urandom);
      v.imm = ($urandom_range(0, 3) == 0) ? v.rs1 : 32'($urandom);
      v.hold = $urandom_range(0, 3);
      v = model(v);
      run_op($sformatf("rnd%0d", i), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
